// File: rtl/if_inst_buffer.sv
// if_inst_buffer: circular FIFO of fetched instruction packets between IF1 and ID.
// Decouples ICache return timing from decode back-pressure and raises the
// fetch-side stall when full. Flush and reset empty it in one cycle.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high and flush/rst are low. in_ready and out_valid depend only
// on registered occupancy. A pop never frees room for a push in the same cycle.
module if_inst_buffer #(
   parameter int WORD  = 32,
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WORD-1:0]  in_pc,
   input  logic [WORD-1:0]  in_inst,
   input  logic             in_pre_branch,
   input  logic [WORD-1:0]  in_pre_pc,
   output logic             in_ready,
   output logic             stall_from_ibuf,
   output logic             out_valid,
   output logic [WORD-1:0]  out_pc,
   output logic [WORD-1:0]  out_inst,
   output logic             out_pre_branch,
   output logic [WORD-1:0]  out_pre_pc,
   input  logic             out_ready,
   output logic [PTR_W:0]   count
);

   typedef struct packed {
      logic [WORD-1:0] pc;
      logic [WORD-1:0] inst;
      logic            pre_branch;
      logic [WORD-1:0] pre_pc;
   } entry_t;

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push, pop;
   entry_t           head_e;

   // Handshake outputs come straight from registered occupancy
   assign in_ready        = (count_q != CNT_FULL);
   assign stall_from_ibuf = ~in_ready;
   assign out_valid       = (count_q != '0);
   assign count           = count_q;

   // Qualify transfers; flush and reset suppress both sides
   assign push = in_valid & in_ready & ~flush & ~rst;
   assign pop  = out_valid & out_ready & ~flush & ~rst;

   // Next-state: pointer advance, occupancy update, tail write
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rst || flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            mem_d[tail_q] = '{pc: in_pc, inst: in_inst,
                              pre_branch: in_pre_branch, pre_pc: in_pre_pc};
            tail_d = tail_q + PTR_ONE;
         end
         if (pop) begin
            head_d = head_q + PTR_ONE;
         end
         if (push && !pop) begin
            count_d = count_q + CNT_ONE;
         end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
         end
      end
   end

   // Control state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are don't-care while not occupied
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Head packet presented to ID, zeroed when the buffer is empty
   always_comb begin
      head_e = '0;
      if (count_q != '0) begin
         head_e = mem_q[head_q];
      end
   end

   assign out_pc         = head_e.pc;
   assign out_inst       = head_e.inst;
   assign out_pre_branch = head_e.pre_branch;
   assign out_pre_pc     = head_e.pre_pc;

endmodule

// File: tb/tb_if_inst_buffer.sv
// Directed bench for if_inst_buffer: reset, latency, fill/back-pressure,
// wrap-around streaming, flush priority, full-plus-pop and mid-run reset.
module tb_if_inst_buffer;

   localparam int WORD  = 32;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   // clock / reset block
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, flush, in_valid, in_pre_branch, out_ready;
   logic [WORD-1:0]  in_pc, in_inst, in_pre_pc;
   logic             in_ready, stall_from_ibuf, out_valid, out_pre_branch;
   logic [WORD-1:0]  out_pc, out_inst, out_pre_pc;
   logic [PTR_W:0]   count;

   if_inst_buffer #(.WORD(WORD), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
      .in_pre_branch(in_pre_branch), .in_pre_pc(in_pre_pc),
      .in_ready(in_ready), .stall_from_ibuf(stall_from_ibuf),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
      .out_pre_branch(out_pre_branch), .out_pre_pc(out_pre_pc),
      .out_ready(out_ready), .count(count)
   );

   // scoreboard
   logic [WORD-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [WORD-1:0] obs,
                        input logic [WORD-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver tasks: advance one edge, settle 1 time unit after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_inst = '0; in_pre_branch = 1'b0; in_pre_pc = '0;
   endtask

   task automatic drive_push(input logic [WORD-1:0] pc);
      in_valid = 1'b1; in_pc = pc; in_inst = pc ^ 32'h0280_0000;
      in_pre_branch = 1'b0; in_pre_pc = pc + 32'd4;
   endtask

   task automatic fill(input logic [WORD-1:0] base, input int n);
      out_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         drive_push(base + 32'(4 * i));
         exp_q.push_back(base + 32'(4 * i));
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      in_valid = 1'b0; out_ready = 1'b1;
      while (exp_q.size() > 0) begin
         check({tag, "_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_pc"}, out_pc, exp_q.pop_front());
         step();
      end
      out_ready = 1'b0;
      check({tag, "_cnt0"}, 32'(count), 32'd0);
   endtask

   initial begin
      // reset with random inputs
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         flush = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1)); in_pc = $urandom;
         in_inst = $urandom; in_pre_branch = 1'($urandom_range(0, 1));
         in_pre_pc = $urandom;
         step();
      end
      rst = 1'b0;
      drive_idle();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("rst_count", 32'(count), 32'd0);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_in_ready", 32'(in_ready), 32'd1);
         check("rst_stall", 32'(stall_from_ibuf), 32'd0);
         check("rst_out_pc", out_pc, 32'd0);
         check("rst_out_inst", out_inst, 32'd0);
         step();
      end

      // latency and pass-through
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h1C00_0000; in_inst = 32'h0280_0C21;
      in_pre_branch = 1'b1; in_pre_pc = 32'h1C00_0040;
      check("lat_no_bypass", 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0;
      check("lat_valid", 32'(out_valid), 32'd1);
      check("lat_pc", out_pc, 32'h1C00_0000);
      check("lat_inst", out_inst, 32'h0280_0C21);
      check("lat_pre_br", 32'(out_pre_branch), 32'd1);
      check("lat_pre_pc", out_pre_pc, 32'h1C00_0040);
      check("lat_count", 32'(count), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("lat_pop_count", 32'(count), 32'd0);
      check("lat_pop_valid", 32'(out_valid), 32'd0);
      check("lat_pop_pc0", out_pc, 32'd0);

      // fill and back-pressure
      fill(32'h1C00_0000, 4);
      check("full_count", 32'(count), 32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_stall", 32'(stall_from_ibuf), 32'd1);
      drive_push(32'h1C00_0010);
      step();
      step();
      in_valid = 1'b0;
      check("full_hold_count", 32'(count), 32'd4);
      drain("fill_drain");

      // wrap-around streaming with concurrent push/pop
      for (int i = 0; i < 10; i++) begin
         drive_push(32'h1C00_1000 + 32'(4 * i));
         out_ready = (i > 0);
         if (i > 0) begin
            check("wrap_count", 32'(count), 32'd1);
            check("wrap_pc", out_pc, exp_q.pop_front());
         end
         exp_q.push_back(32'h1C00_1000 + 32'(4 * i));
         step();
      end
      drain("wrap_drain");

      // flush priority over push and pop
      fill(32'h1C00_2000, 3);
      check("flush_pre_count", 32'(count), 32'd3);
      exp_q.delete();
      drive_push(32'h1C00_2FF0);
      out_ready = 1'b1; flush = 1'b1;
      step();
      drive_idle();
      check("flush_count", 32'(count), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_in_ready", 32'(in_ready), 32'd1);
      check("flush_out_pc", out_pc, 32'd0);
      step();
      check("flush_stays_empty", 32'(count), 32'd0);

      // full plus pop: pop happens, held packet accepted next cycle
      fill(32'h1C00_3000, 4);
      check("fp_full", 32'(count), 32'd4);
      drive_push(32'h1C00_3010);
      out_ready = 1'b1;
      step();
      void'(exp_q.pop_front());
      check("fp_count3", 32'(count), 32'd3);
      check("fp_in_ready", 32'(in_ready), 32'd1);
      check("fp_head", out_pc, exp_q[0]);
      out_ready = 1'b0;
      step();
      exp_q.push_back(32'h1C00_3010);
      in_valid = 1'b0;
      check("fp_count4", 32'(count), 32'd4);
      drain("fp_drain");

      // reset mid-operation with a push offered
      fill(32'h1C00_4000, 2);
      exp_q.delete();
      drive_push(32'h1C00_4FF0);
      out_ready = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0;
      drive_idle();
      check("mrst_count", 32'(count), 32'd0);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_out_pc", out_pc, 32'd0);
      check("mrst_out_pre_pc", out_pre_pc, 32'd0);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
